// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// The TX side reuses the same defaults.
package uart_pkg;

  localparam int DATA_BITS_DEFAULT   = 8;
  localparam int SAMPLE_RATE_DEFAULT = 16;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Received-word bus from the UART receiver to the command/FIFO logic.
// The receiver drives through the master modport; consumers use the slave modport.
interface uart_rx_deserializer_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
);

  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 framing_error;
  logic                 parity_error;

  modport master (output data, data_valid, framing_error, parity_error);
  modport slave  (input  data, data_valid, framing_error, parity_error);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector. All flops reset high so an idle line never looks like a start edge.
module uart_rx_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic rx,
  output logic level,
  output logic fall
);

  logic meta;
  logic synced;
  logic prev;

  // NOTE: non-blocking assignments keep the three flops a true shift chain;
  // blocking ones would collapse them into a single stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b1;
      synced <= 1'b1;
      prev   <= 1'b1;
    end else begin
      meta   <= rx;
      synced <= meta;
      prev   <= synced;
    end
  end

  assign level = synced;
  assign fall  = prev & ~synced;

endmodule

// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: start-edge detection, mid-bit sampling, LSB-first
// deserialization. Define UART_RX_PARITY_EN to add an even-parity bit per frame.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int SAMPLE_RATE = SAMPLE_RATE_DEFAULT   // even, >= 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    rx,
  input  logic                    tick,
  output logic                    start_rx,
  output logic                    busy,
  uart_rx_deserializer_if.master  word
);

  localparam int TICK_W = $clog2(SAMPLE_RATE);
  localparam int CNT_W  = $clog2(DATA_BITS) + 1;

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(SAMPLE_RATE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_RATE - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);

  logic                 level;
  logic                 fall;
  uart_rx_state_t       state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q;
  logic                 perr_pend;
`endif

  uart_rx_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .rx      (rx),
    .level   (level),
    .fall    (fall)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RX_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      start_rx <= 1'b0;
      busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      perr_pend <= 1'b0;
`endif
    end else begin
      start_rx <= 1'b0;
      valid_q  <= 1'b0;
      case (state)
        RX_IDLE: begin
          busy <= 1'b0;
          // A tick in the same cycle as the edge is deliberately dropped.
          if (fall) begin
            start_rx <= 1'b1;
            tick_cnt <= '0;
            state    <= RX_START;
          end
        end
        RX_START: begin
          busy <= 1'b1;
          if (tick) begin
            if (tick_cnt == TICK_MID) begin
              if (level) begin
                state <= RX_IDLE;
                busy  <= 1'b0;
              end else begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
                state    <= RX_DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        RX_DATA: begin
          busy <= 1'b1;
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              shift    <= {level, shift[DATA_BITS-1:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= RX_PARITY;
`else
                state <= RX_STOP;
`endif
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          busy <= 1'b1;
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              perr_pend <= ^shift ^ level;
              tick_cnt  <= '0;
              state     <= RX_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        RX_STOP: begin
          busy <= 1'b1;
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              // Returning mid stop bit leaves room for a back-to-back start edge.
              data_q   <= shift;
              valid_q  <= 1'b1;
              ferr_q   <= ~level;
`ifdef UART_RX_PARITY_EN
              perr_q   <= perr_pend;
`endif
              tick_cnt <= '0;
              busy     <= 1'b0;
              state    <= RX_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= RX_IDLE;
        end
      endcase
    end
  end

  assign word.data          = data_q;
  assign word.data_valid    = valid_q;
  assign word.framing_error = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign word.parity_error  = perr_q;
`else
  assign word.parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer; models the baud generator's tick with
// start_rx realignment. Parity scenarios compile in when UART_RX_PARITY_EN is set.
module tb_uart_rx_deserializer;

  // Tick divider scaled down from the 163-clock board value to keep runs short;
  // the receiver only sees ticks, so frame behaviour is unchanged.
  localparam int TICK_DIV = 16;
  localparam int BIT      = TICK_DIV * 16;
  localparam int GLITCH   = 90;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic rx      = 1'b1;
  logic tick;
  logic start_rx;
  logic busy;

  int checks = 0;
  int errors = 0;

  uart_rx_deserializer_if #(.DATA_BITS(8)) word_if ();

  uart_rx_deserializer #(.DATA_BITS(8), .SAMPLE_RATE(16)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx       (rx),
    .tick     (tick),
    .start_rx (start_rx),
    .busy     (busy),
    .word     (word_if)
  );

  always #5 clock = ~clock;

  int div;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          div <= 0;
    else if (start_rx || div == TICK_DIV-1) div <= 0;
    else                                   div <= div + 1;
  end
  assign tick = (div == TICK_DIV - 1);

  int         dv_count    = 0;
  int         start_count = 0;
  logic [7:0] dv_data[$];

  always @(negedge clock) begin
    if (word_if.data_valid) begin
      dv_count <= dv_count + 1;
      dv_data.push_back(word_if.data);
    end
    if (start_rx) start_count <= start_count + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clk(BIT);
  endtask

  task automatic send_tail(input logic [7:0] d, input logic stop_b);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_b);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    drive_bit(1'b0);
    send_tail(d, stop_b);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_clk(3);
    checks++; if (start_rx !== 1'b0) begin errors++; $display("FAIL reset_start_rx got %b expected 0", start_rx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (word_if.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h expected 00", word_if.data); end
    checks++; if (word_if.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", word_if.data_valid); end
    checks++; if (word_if.framing_error !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b expected 0", word_if.framing_error); end
    checks++; if (word_if.parity_error !== 1'b0) begin errors++; $display("FAIL reset_perr got %b expected 0", word_if.parity_error); end
    reset_n = 1'b1;
    wait_clk(5);
    checks++; if (start_count !== 0) begin errors++; $display("FAIL idle_no_start got %0d expected 0", start_count); end
  endtask

  task automatic test_frame();
    int base_dv;
    base_dv = dv_count;
    rx = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (start_rx !== 1'b0) begin errors++; $display("FAIL start_rx_early got %b expected 0", start_rx); end
    @(negedge clock);
    checks++; if (start_rx !== 1'b1) begin errors++; $display("FAIL start_rx_latency got %b expected 1", start_rx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_with_start got %b expected 0", busy); end
    @(negedge clock);
    checks++; if (start_rx !== 1'b0) begin errors++; $display("FAIL start_rx_width got %b expected 0", start_rx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b expected 1", busy); end
    wait_clk(BIT - 4);
    send_tail(8'hA5, 1'b1);
    wait_clk(2);
    checks++; if (dv_count !== base_dv + 1) begin errors++; $display("FAIL a5_valid_count got %0d expected %0d", dv_count, base_dv + 1); end
    checks++; if (dv_data[$] !== 8'hA5) begin errors++; $display("FAIL a5_captured got %h expected a5", dv_data[$]); end
    checks++; if (word_if.data !== 8'hA5) begin errors++; $display("FAIL a5_data got %h expected a5", word_if.data); end
    checks++; if (word_if.framing_error !== 1'b0) begin errors++; $display("FAIL a5_ferr got %b expected 0", word_if.framing_error); end
    checks++; if (word_if.parity_error !== 1'b0) begin errors++; $display("FAIL a5_perr got %b expected 0", word_if.parity_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_after got %b expected 0", busy); end
  endtask

  task automatic test_false_start();
    int base_dv, base_st;
    base_dv = dv_count;
    base_st = start_count;
    rx = 1'b0;
    wait_clk(20);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b expected 1", busy); end
    wait_clk(GLITCH - 20);
    rx = 1'b1;
    wait_clk(BIT);
    checks++; if (start_count !== base_st + 1) begin errors++; $display("FAIL glitch_starts got %0d expected %0d", start_count, base_st + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_after got %b expected 0", busy); end
    checks++; if (dv_count !== base_dv) begin errors++; $display("FAIL glitch_no_valid got %0d expected %0d", dv_count, base_dv); end
  endtask

  task automatic test_framing_error();
    int base_dv, base_st;
    base_dv = dv_count;
    base_st = start_count;
    send_frame(8'h3C, 1'b0);
    wait_clk(2);
    checks++; if (dv_count !== base_dv + 1) begin errors++; $display("FAIL fe_valid_count got %0d expected %0d", dv_count, base_dv + 1); end
    checks++; if (word_if.data !== 8'h3C) begin errors++; $display("FAIL fe_data got %h expected 3c", word_if.data); end
    checks++; if (word_if.framing_error !== 1'b1) begin errors++; $display("FAIL fe_flag got %b expected 1", word_if.framing_error); end
    wait_clk(2 * BIT);
    checks++; if (start_count !== base_st + 1) begin errors++; $display("FAIL fe_low_no_start got %0d expected %0d", start_count, base_st + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_low_busy got %b expected 0", busy); end
    rx = 1'b1;
    wait_clk(BIT);
    send_frame(8'h5A, 1'b1);
    wait_clk(2);
    checks++; if (start_count !== base_st + 2) begin errors++; $display("FAIL fe_restart got %0d expected %0d", start_count, base_st + 2); end
    checks++; if (word_if.data !== 8'h5A) begin errors++; $display("FAIL fe_next_data got %h expected 5a", word_if.data); end
    checks++; if (word_if.framing_error !== 1'b0) begin errors++; $display("FAIL fe_next_flag got %b expected 0", word_if.framing_error); end
  endtask

  task automatic test_back_to_back();
    int base_dv;
    base_dv = dv_count;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_clk(2);
    checks++; if (dv_count !== base_dv + 2) begin errors++; $display("FAIL b2b_valid_count got %0d expected %0d", dv_count, base_dv + 2); end
    checks++; if (dv_data[$-1] !== 8'h00) begin errors++; $display("FAIL b2b_first got %h expected 00", dv_data[$-1]); end
    checks++; if (dv_data[$] !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h expected ff", dv_data[$]); end
    checks++; if (word_if.framing_error !== 1'b0) begin errors++; $display("FAIL b2b_ferr got %b expected 0", word_if.framing_error); end
    checks++; if (word_if.parity_error !== 1'b0) begin errors++; $display("FAIL b2b_perr got %b expected 0", word_if.parity_error); end
  endtask

  task automatic test_reset_mid_frame();
    int base_dv;
    logic [7:0] d;
    d = 8'h81;
    base_dv = dv_count;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    wait_clk(BIT / 2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b expected 1", busy); end
    reset_n = 1'b0;
    rx = 1'b1;
    wait_clk(5);
    checks++; if (word_if.data !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h expected 00", word_if.data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b expected 0", busy); end
    checks++; if (word_if.framing_error !== 1'b0) begin errors++; $display("FAIL mid_rst_ferr got %b expected 0", word_if.framing_error); end
    reset_n = 1'b1;
    wait_clk(2 * BIT);
    checks++; if (dv_count !== base_dv) begin errors++; $display("FAIL mid_rst_no_valid got %0d expected %0d", dv_count, base_dv); end
    send_frame(8'h81, 1'b1);
    wait_clk(2);
    checks++; if (dv_count !== base_dv + 1) begin errors++; $display("FAIL post_rst_count got %0d expected %0d", dv_count, base_dv + 1); end
    checks++; if (word_if.data !== 8'h81) begin errors++; $display("FAIL post_rst_data got %h expected 81", word_if.data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_parity_frame(input logic [7:0] d, input logic par_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par_b);
    drive_bit(1'b1);
  endtask

  task automatic test_parity();
    send_parity_frame(8'h07, 1'b1);
    wait_clk(2);
    checks++; if (word_if.parity_error !== 1'b0) begin errors++; $display("FAIL par_good got %b expected 0", word_if.parity_error); end
    checks++; if (word_if.data !== 8'h07) begin errors++; $display("FAIL par_good_data got %h expected 07", word_if.data); end
    send_parity_frame(8'h07, 1'b0);
    wait_clk(2);
    checks++; if (word_if.parity_error !== 1'b1) begin errors++; $display("FAIL par_bad got %b expected 1", word_if.parity_error); end
    checks++; if (word_if.data !== 8'h07) begin errors++; $display("FAIL par_bad_data got %h expected 07", word_if.data); end
    checks++; if (word_if.framing_error !== 1'b0) begin errors++; $display("FAIL par_bad_ferr got %b expected 0", word_if.framing_error); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_false_start();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Oversampling UART receiver that turns the asynchronous serial input into parallel bytes. It sits directly downstream of the baud rate generator and consumes its `tick` (SAMPLE_RATE ticks per bit). It drives the generator's `start_rx` so tick phase realigns to each detected start edge. Output words go to the command/FIFO logic with a one-cycle valid strobe.

## Interface
- `DATA_BITS`, 8: data bits per frame, sent LSB first.
- `SAMPLE_RATE`, 16: ticks per bit period; must be even and ≥ 4.
- `clock` input, 1: system clock.
- `reset_n` input, 1: asynchronous, active-low reset.
- `rx` input, 1: serial line, idle high, asynchronous to `clock`.
- `tick` input, 1: oversample strobe from the baud rate generator.
- `start_rx` output, 1: one-cycle pulse on an accepted start edge; feeds the generator.
- `data` output, DATA_BITS: last received word, held until the next frame completes.
- `data_valid` output, 1: one-cycle pulse when `data` updates.
- `framing_error` output, 1: stop bit sampled low; updates with `data_valid`.
- `parity_error` output, 1: parity mismatch; updates with `data_valid`. Tied 0 without the macro.
- `busy` output, 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (flops reset to 1), then a previous-value register for edge detection.
- States: IDLE, START, DATA, PARITY (macro only), STOP. `tick_cnt` is log2(SAMPLE_RATE) bits wide. `bit_cnt` is clog2(DATA_BITS)+1 bits wide.
- IDLE:
  - A falling edge on synced `rx` (prev 1, now 0) pulses `start_rx`, clears `tick_cnt`, and enters START.
  - `tick` is ignored in IDLE.
- START: `tick_cnt` increments on each `tick`. On the tick where `tick_cnt == SAMPLE_RATE/2-1` (mid start bit):
  - If synced `rx` is 1, it is a false start: return to IDLE with no outputs.
  - Otherwise clear `tick_cnt` and `bit_cnt` and enter DATA.
- DATA:
  - On the tick where `tick_cnt == SAMPLE_RATE-1`, shift synced `rx` into the MSB of the shift register (shift right), clear `tick_cnt`, and increment `bit_cnt`.
  - After DATA_BITS samples, go to PARITY (macro) or STOP.
- PARITY: sampled on the same tick rule. Even parity is expected: XOR of data and parity bit equals 0.
- STOP: sampled on the same tick rule. In the cycle after that sampling tick:
  - `data` ← shift register.
  - `data_valid` pulses for one cycle.
  - `framing_error` ← stop sample == 0.
  - `parity_error` ← mismatch.
  - State returns to IDLE.
- Data is delivered even when a framing or parity error is flagged.
- After a framing error (line still low), IDLE waits for `rx` to rise and then fall again before starting a new frame.

## Timing
- Reset values: `start_rx` 0, `data` 0, `data_valid` 0, `framing_error` 0, `parity_error` 0, `busy` 0, state IDLE, counters 0.
- Pin falling edge to `start_rx` pulse: 3 clocks (2 synchronizer + 1 edge register).
- `data_valid` is registered and asserts in the clock after the stop-sample tick.
- Sampling happens mid-bit. Return to IDLE happens mid stop bit, so back-to-back frames are accepted.
- Reset asserted mid-frame: immediate return to IDLE and the partial word is discarded. `data` and the flags clear to 0.
- `tick` and a start edge in the same cycle in IDLE: the edge wins and that tick is not counted.
- `busy` goes high the cycle after `start_rx` and low in the cycle `data_valid` pulses, or on a false start.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists and the frame is 1 start + DATA_BITS + 1 even parity + 1 stop. `parity_error` is live.
- `UART_RX_PARITY_EN` undefined: no PARITY state, 8N1 framing, `parity_error` constant 0. Port list is unchanged.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_rx_state_t`
  - default `DATA_BITS`/`SAMPLE_RATE` constants, reused by the TX side
- Sub-module `uart_rx_sync`: 2-flop synchronizer plus falling-edge detector. Outputs synced level and `fall` pulse; flops reset high.

## Test plan
Common setup: instantiate with the baud rate generator (CLK_HZ 25 MHz, 9600 baud, divisor 162, so 163 clocks per tick). Bench bit period is 2608 clocks.
- Frame 0xA5, stop 1 -> one `data_valid` pulse, `data`=0xA5, `framing_error`=0, `busy` low afterwards.
- Low glitch of 1000 clocks on idle `rx` -> `start_rx` pulses once, `busy` rises, then returns to IDLE. No `data_valid`.
- Frame 0x3C with stop bit 0 -> `data`=0x3C, `framing_error`=1. No new frame until `rx` rises and falls again.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two `data_valid` pulses with `data` 0x00 then 0xFF. Both error flags 0.
- `reset_n` low for 5 clocks in the middle of bit 4 of frame 0x81 -> all outputs 0, no `data_valid`. The following clean 0x81 frame is received correctly.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 -> `parity_error`=0. Same data with parity bit 0 -> `parity_error`=1, `data`=0x07.
